// File: rtl/mac2ibuf_pkg.sv
// Shared types for the MAC-RX to ibuf writer: FSM states, drop causes,
// header field layout and the saturating counter helper.
package mac2ibuf_pkg;

  typedef enum logic [2:0] {
    S_INIT, S_WAIT_HOST, S_WAIT_IDLE, S_WAIT_SOF, S_RECV, S_COMMIT, S_DROP
  } state_t;

  typedef enum logic {DC_FULL, DC_LEN} drop_cause_t;

  localparam int HDR_TS_LSB  = 0;
  localparam int HDR_TS_W    = 32;
  localparam int HDR_LEN_LSB = 32;
  localparam int HDR_LEN_W   = 16;

  function automatic logic [15:0] ctr_sat16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/mac2ibuf_filt_bytes_from_mask.sv
// Byte count of a MAC byte-enable mask plus a flag for non-contiguous masks.
module bytes_from_mask (
  input  logic [7:0] mask,
  output logic [3:0] nbytes,
  output logic       malformed
);
  always_comb begin
    nbytes = '0;
    for (int i = 0; i < 8; i++) nbytes = nbytes + {3'b0, mask[i]};
  end

  // a well-formed mask is 2^n-1, so adding one never overlaps its set bits
  assign malformed = (mask & (mask + 8'd1)) != 8'd0;
endmodule

// File: rtl/mac2ibuf_filt.sv
// MAC-RX to ring-buffer writer with descriptor header, runt/oversize/full/bad
// filtering and saturating drop counters. Optional: MAC2IBUF_TSTAMP_EN.
module mac2ibuf_filt
  import mac2ibuf_pkg::*;
#(
  parameter int BW      = 10,
  parameter int GUARD   = 10,
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1518
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   rx_data,
  input  logic [7:0]    rx_data_valid,
  input  logic          rx_good_frame,
  input  logic          rx_bad_frame,
  output logic          wr_en,
  output logic [BW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  input  logic          hst_rdy,
  output logic          activity,
  output logic [BW:0]   committed_prod,
  input  logic [BW:0]   committed_cons,
  output logic [15:0]   drop_full,
  output logic [15:0]   drop_bad,
  output logic [15:0]   drop_len
);
  localparam int          OCC_MAX_I = (1 << BW) - GUARD;
  localparam logic [BW:0] OCC_MAX   = OCC_MAX_I[BW:0];
  localparam logic [BW:0] ONE       = {{BW{1'b0}}, 1'b1};

  state_t        state, nx;
  drop_cause_t   cause_q, cause_nx;
  logic [1:0]    rdy_sync;
  logic [BW:0]   aux_q, aux_base, aux_nx, occ_q, prod_q;
  logic [15:0]   len_q, len_base, len_nx;
  logic          bad_q, bad_base, bad_nx;
  logic [3:0]    nb;
  logic          mal, word, eof;
  logic          do_write, do_hdr, inc_full, inc_bad, inc_len;
  logic [63:0]   hdr;
  logic [31:0]   ts_lat;

  bytes_from_mask u_bfm (.mask(rx_data_valid), .nbytes(nb), .malformed(mal));

  assign activity       = wr_en;
  assign committed_prod = prod_q;

  // WAIT_SOF restarts the running frame state from the committed pointer
  always_comb begin
    word     = |rx_data_valid;
    eof      = rx_good_frame | rx_bad_frame;
    aux_base = (state == S_WAIT_SOF) ? prod_q + ONE : aux_q;
    len_base = (state == S_WAIT_SOF) ? 16'd0 : len_q;
    bad_base = (state == S_WAIT_SOF) ? 1'b0 : bad_q;
    aux_nx   = aux_base + {{BW{1'b0}}, word};
    len_nx   = len_base + {12'd0, nb};
    bad_nx   = bad_base | (word & mal);
  end

  always_comb begin
    nx       = state;
    cause_nx = cause_q;
    do_write = 1'b0;
    do_hdr   = 1'b0;
    inc_full = 1'b0;
    inc_bad  = 1'b0;
    inc_len  = 1'b0;
    case (state)
      S_INIT:      nx = S_WAIT_HOST;
      S_WAIT_HOST: if (rdy_sync[1]) nx = S_WAIT_IDLE;
      S_WAIT_IDLE: if (!word) nx = S_WAIT_SOF;
      S_WAIT_SOF, S_RECV: begin
        if (state == S_RECV && occ_q > OCC_MAX) begin
          if (eof) begin inc_full = 1'b1; nx = S_WAIT_SOF; end
          else     begin cause_nx = DC_FULL; nx = S_DROP; end
        end else if (state == S_RECV || word) begin
          do_write = word;
          nx       = S_RECV;
          if (len_nx > 16'(MAX_LEN)) begin
            if (eof) begin inc_len = 1'b1; nx = S_WAIT_SOF; end
            else     begin cause_nx = DC_LEN; nx = S_DROP; end
          end else if (eof) begin
            if (rx_bad_frame || bad_nx)       begin inc_bad = 1'b1; nx = S_WAIT_SOF; end
            else if (len_nx < 16'(MIN_LEN))   begin inc_len = 1'b1; nx = S_WAIT_SOF; end
            else                              nx = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        do_hdr = 1'b1;
        // data arriving here broke the inter-frame gap; skip it until idle
        if (word) begin inc_bad = 1'b1; nx = S_WAIT_IDLE; end
        else      nx = S_WAIT_SOF;
      end
      S_DROP: if (eof) begin
        if (cause_q == DC_FULL) inc_full = 1'b1;
        else                    inc_len  = 1'b1;
        nx = S_WAIT_SOF;
      end
      default: nx = S_INIT;
    endcase
  end

  always_comb begin
    hdr = '0;
    hdr[HDR_LEN_LSB +: HDR_LEN_W] = len_q;
    hdr[HDR_TS_LSB  +: HDR_TS_W]  = ts_lat;
  end

`ifdef MAC2IBUF_TSTAMP_EN
  logic [31:0] ts_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q   <= '0;
      ts_lat <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (state == S_WAIT_SOF && word) ts_lat <= ts_q;
    end
  end
`else
  assign ts_lat = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      cause_q   <= DC_FULL;
      rdy_sync  <= '0;
      aux_q     <= '0;
      len_q     <= '0;
      bad_q     <= 1'b0;
      occ_q     <= '0;
      prod_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      drop_full <= '0;
      drop_bad  <= '0;
      drop_len  <= '0;
    end else begin
      state    <= nx;
      cause_q  <= cause_nx;
      rdy_sync <= {rdy_sync[0], hst_rdy};
      occ_q    <= aux_nx - committed_cons;
      if (state == S_WAIT_SOF || state == S_RECV) begin
        aux_q <= aux_nx;
        len_q <= len_nx;
        bad_q <= bad_nx;
      end
      wr_en <= do_write | do_hdr;
      if (do_write) begin
        wr_addr <= aux_base[BW-1:0];
        wr_data <= rx_data;
      end else if (do_hdr) begin
        // header and pointer move together so the frame appears atomically
        wr_addr <= prod_q[BW-1:0];
        wr_data <= hdr;
        prod_q  <= aux_q;
      end
      if (inc_full) drop_full <= ctr_sat16(drop_full);
      if (inc_bad)  drop_bad  <= ctr_sat16(drop_bad);
      if (inc_len)  drop_len  <= ctr_sat16(drop_len);
    end
  end

endmodule

// File: tb/tb_mac2ibuf_filt.sv
// Scoreboard bench for mac2ibuf_filt: frame-level reference model, shadow ibuf
// memory, commits checked by a monitor whenever committed_prod moves.
module tb_mac2ibuf_filt;
  localparam int BW = 10, GUARD = 10, MIN_LEN = 60, MAX_LEN = 1518;
  localparam int RING = 1 << BW, PMASK = (2 * RING) - 1, OCC_MAX = RING - GUARD;

  logic          clk = 0, rst = 1;
  logic [63:0]   rx_data = '0;
  logic [7:0]    rx_data_valid = '0;
  logic          rx_good_frame = 0, rx_bad_frame = 0, hst_rdy = 0;
  logic          wr_en, activity;
  logic [BW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic [BW:0]   committed_prod, committed_cons = '0;
  logic [15:0]   drop_full, drop_bad, drop_len;

  mac2ibuf_filt #(.BW(BW), .GUARD(GUARD), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_good_frame(rx_good_frame), .rx_bad_frame(rx_bad_frame),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .hst_rdy(hst_rdy),
    .activity(activity), .committed_prod(committed_prod), .committed_cons(committed_cons),
    .drop_full(drop_full), .drop_bad(drop_bad), .drop_len(drop_len));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int m_prod = 0, m_cons = 0, m_full = 0, m_bad = 0, m_len = 0;
  int          exp_len[$], exp_nw[$];
  logic [63:0] exp_words[$];
  logic [63:0] mem [RING];
  logic [BW:0] prev_prod = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: shadow every write, validate a frame whenever the pointer moves
  always @(negedge clk) begin
    if (rst) prev_prod = '0;
    else begin
      chk("activity_eq_wr_en", 64'(activity), 64'(wr_en));
      if (wr_en) mem[wr_addr] = wr_data;
      if (committed_prod !== prev_prod) begin
        if (exp_len.size() == 0) chk("unexpected_commit", 64'(committed_prod), 64'(prev_prod));
        else begin
          automatic int ln = exp_len.pop_front();
          automatic int nw = exp_nw.pop_front();
          automatic logic [63:0] h = mem[prev_prod[BW-1:0]];
          chk("hdr_len", 64'(h[47:32]), 64'(ln));
          chk("hdr_rsvd", 64'(h[63:48]), 64'd0);
`ifndef MAC2IBUF_TSTAMP_EN
          chk("hdr_ts", 64'(h[31:0]), 64'd0);
`endif
          for (int i = 0; i < nw; i++)
            chk("data_word", mem[(int'(prev_prod) + 1 + i) % RING], exp_words.pop_front());
          chk("prod_step", 64'(committed_prod), 64'((int'(prev_prod) + nw + 1) & PMASK));
        end
        prev_prod = committed_prod;
      end
    end
  end

  task automatic cycle(input logic [7:0] v, input logic [63:0] d, input logic g, input logic b);
    @(posedge clk); #1;
    rx_data_valid = v; rx_data = d; rx_good_frame = g; rx_bad_frame = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, '0, 0, 0);
  endtask

  task automatic set_cons(input int c);
    m_cons = c & PMASK;
    committed_cons = m_cons[BW:0];
  endtask

  // kind: 0 good, 1 rx_bad eof, 2 malformed mask mid-frame with good eof
  task automatic send_frame(input int nbytes, input int kind, input bit bubbles);
    logic [7:0]  masks[$];
    logic [63:0] dw[$];
    int rem, nb, n, occ;
    rem = nbytes; nb = 0;
    while (rem > 0) begin
      automatic int t = (rem >= 8) ? 8 : rem;
      masks.push_back(8'((1 << t) - 1));
      rem -= t;
    end
    n = masks.size();
    if (kind == 2) masks[n/2] = 8'h05;
    foreach (masks[i]) begin
      nb += $countones(masks[i]);
      dw.push_back({$urandom, $urandom});
    end
    occ = (m_prod + 1 + n - m_cons) & PMASK;
    if (occ > OCC_MAX)     m_full++;
    else if (nb > MAX_LEN) m_len++;
    else if (kind != 0)    m_bad++;
    else if (nb < MIN_LEN) m_len++;
    else begin
      exp_len.push_back(nb);
      exp_nw.push_back(n);
      foreach (dw[i]) exp_words.push_back(dw[i]);
      m_prod = (m_prod + n + 1) & PMASK;
    end
    foreach (masks[i]) begin
      if (bubbles && i > 0 && $urandom_range(7) == 0) cycle(8'h00, '0, 0, 0);
      cycle(masks[i], dw[i], 0, 0);
    end
    if (kind == 1) cycle(8'h00, '0, 1'($urandom_range(1)), 1);
    else           cycle(8'h00, '0, 1, 0);
    idle(2);
  endtask

  task automatic chk_model(input string tag);
    idle(3);
    chk({tag, "_prod"}, 64'(committed_prod), 64'(m_prod));
    chk({tag, "_drop_full"}, 64'(drop_full), 64'(m_full));
    chk({tag, "_drop_bad"}, 64'(drop_bad), 64'(m_bad));
    chk({tag, "_drop_len"}, 64'(drop_len), 64'(m_len));
    chk({tag, "_pending"}, 64'(exp_len.size()), 64'd0);
  endtask

  initial begin
    hst_rdy = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_activity", 64'(activity), 64'd0);
    chk("rst_prod", 64'(committed_prod), 64'd0);
    chk("rst_counters", {16'd0, drop_full, drop_bad, drop_len}, 64'd0);
    rst = 0;
    idle(8);

    send_frame(64, 0, 0);
    idle(2);
    chk("first_prod", 64'(committed_prod), 64'd9);
    chk("first_hdr_addr0_len", 64'(mem[0][47:32]), 64'd64);
    send_frame(61, 0, 0);
    chk("second_prod", 64'(committed_prod), 64'd18);
    send_frame(40, 0, 0);
    send_frame(1600, 0, 0);
    idle(2);
    chk("len_drops", 64'(drop_len), 64'd2);
    send_frame(64, 2, 0);
    send_frame(64, 1, 0);
    idle(2);
    chk("bad_drops", 64'(drop_bad), 64'd2);
    chk_model("directed");

    for (int f = 0; f < 80; f++) begin
      automatic int r = $urandom_range(9);
      if (r == 0) begin
        set_cons(m_prod);
        idle(1);
        send_frame($urandom_range(1519, 1700), 0, 1);
      end else begin
        automatic int k = $urandom_range(5);
        if ($urandom_range(1) == 1)
          set_cons(m_cons + $urandom_range(0, (m_prod - m_cons) & PMASK));
        idle(1);
        send_frame($urandom_range(8, 400), (k == 4) ? 1 : (k == 5) ? 2 : 0, 1);
      end
    end
    chk_model("random");

    // reset mid-frame: partial frame must leave nothing behind
    for (int i = 0; i < 4; i++) cycle(8'hFF, {$urandom, $urandom}, 0, 0);
    @(posedge clk); #1;
    rst = 1; rx_data_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    m_prod = 0; m_full = 0; m_bad = 0; m_len = 0;
    exp_len.delete(); exp_nw.delete(); exp_words.delete();
    set_cons(0);
    idle(8);
    send_frame(64, 0, 0);
    idle(2);
    chk("post_rst_prod", 64'(committed_prod), 64'd9);

    for (int f = 0; f < 114; f++) send_frame(64, 0, 0);
    chk_model("fill");
    chk("fill_dropped_some", 64'(drop_full != 0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
